// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RISE = 2'd2,
      WAIT_FALL = 2'd3
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker: first valid index after pointer, wrapping.
module rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GNT_W   = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [GNT_W-1:0]   pointer,
   output logic [GNT_W-1:0]   winner,
   output logic               any
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   int unsigned          w;

   // Rotate so that bit 0 is the index just after the pointer.
   always_comb begin
      dbl = {valid, valid} >> (32'(pointer) + 1);
      rot = dbl[NUM_REQ-1:0];
   end

   // Lowest set bit of the rotated vector, mapped back to an absolute index.
   always_comb begin
      any    = 1'b0;
      w      = 0;
      winner = pointer;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!any && rot[j]) begin
            any = 1'b1;
            w   = 32'(pointer) + 1 + j;
            if (w >= NUM_REQ) w = w - NUM_REQ;
            winner = GNT_W'(w);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional burst lock enabled by defining UART_ARB_LOCK_EN (adds req_lock port).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned GNT_W    = 2,
   parameter int unsigned BUSY_TMO = 15,
   parameter int unsigned TMO_W    = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   input  logic                      tx_busy,
   output logic                      tx_data_valid,
   output logic [BYTE_W-1:0]         tx_p_data,
   output logic [GNT_W-1:0]          grant_id,
   output logic                      arb_busy,
   output logic                      tmo_err
);

   state_t              state, state_n;
   logic [GNT_W-1:0]    ptr, ptr_n, grant_n;
   logic [GNT_W-1:0]    pick_idx, win_idx;
   logic                pick_any, lock_hit;
   logic [BYTE_W-1:0]   win_byte, data_n;
   logic [TMO_W-1:0]    cnt, cnt_n;
   logic [NUM_REQ-1:0]  ready_n;
   logic                valid_n, tmo_n;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .GNT_W   (GNT_W)
   ) u_picker (
      .valid   (req_valid),
      .pointer (ptr),
      .winner  (pick_idx),
      .any     (pick_any)
   );

   // A locked, still-valid previous grantee bypasses the rotation.
`ifdef UART_ARB_LOCK_EN
   assign lock_hit = req_lock[grant_id] & req_valid[grant_id];
`else
   assign lock_hit = 1'b0;
`endif
   assign win_idx = lock_hit ? grant_id : pick_idx;

   // Select the winner's byte from the flat request bus.
   always_comb begin
      win_byte = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (GNT_W'(i) == win_idx) win_byte = req_data[i*BYTE_W +: BYTE_W];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      grant_n = grant_id;
      data_n  = tx_p_data;
      cnt_n   = '0;
      valid_n = 1'b0;
      ready_n = '0;
      tmo_n   = 1'b0;
      case (state)
         IDLE: begin
            // A Busy TX here belongs to a frame we did not issue; wait it out.
            if (pick_any && !tx_busy) begin
               state_n = ISSUE;
               ptr_n   = win_idx;
               grant_n = win_idx;
               data_n  = win_byte;
               valid_n = 1'b1;
               ready_n = NUM_REQ'(1) << win_idx;
            end
         end
         ISSUE: state_n = WAIT_RISE;
         WAIT_RISE: begin
            if (tx_busy) begin
               state_n = WAIT_FALL;
            end else if (cnt == TMO_W'(BUSY_TMO - 1)) begin
               state_n = IDLE;
               tmo_n   = 1'b1;
            end else begin
               cnt_n = cnt + TMO_W'(1);
            end
         end
         WAIT_FALL: if (!tx_busy) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         ptr           <= GNT_W'(NUM_REQ - 1);
         grant_id      <= '0;
         tx_p_data     <= '0;
         cnt           <= '0;
         tx_data_valid <= 1'b0;
         req_ready     <= '0;
         arb_busy      <= 1'b0;
         tmo_err       <= 1'b0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         grant_id      <= grant_n;
         tx_p_data     <= data_n;
         cnt           <= cnt_n;
         tx_data_valid <= valid_n;
         req_ready     <= ready_n;
         arb_busy      <= (state_n != IDLE);
         tmo_err       <= tmo_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART TX Busy model.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
`ifdef UART_ARB_LOCK_EN
   logic [3:0]  req_lock;
`endif
   logic        tx_busy;
   logic        tx_data_valid;
   logic [7:0]  tx_p_data;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        tmo_err;

   logic        force_busy;
   logic        model_en;
   logic [3:0]  model_cnt = 4'd0;

   int total  = 0;
   int passed = 0;

   uart_tx_arbiter dut (
      .CLK           (CLK),
      .RST           (RST),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
`ifdef UART_ARB_LOCK_EN
      .req_lock      (req_lock),
`endif
      .tx_busy       (tx_busy),
      .tx_data_valid (tx_data_valid),
      .tx_p_data     (tx_p_data),
      .grant_id      (grant_id),
      .arb_busy      (arb_busy),
      .tmo_err       (tmo_err)
   );

   always #5 CLK = ~CLK;

   // TX model: Busy for 11 cycles starting the cycle after a Data_Valid pulse.
   always @(posedge CLK) begin
      if (!model_en)               model_cnt <= 4'd0;
      else if (model_cnt != 4'd0)  model_cnt <= model_cnt - 4'd1;
      else if (tx_data_valid)      model_cnt <= 4'd11;
   end

   assign tx_busy = force_busy | (model_cnt != 4'd0);

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_issue(input int max_cyc);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!tx_data_valid && n < max_cyc);
      chk("issue_seen", 32'(tx_data_valid), 32'd1);
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while ((arb_busy || tx_busy) && n < max_cyc) begin
         step();
         n++;
      end
      chk("idle_reached", 32'({arb_busy, tx_busy}), 32'd0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int early;
      int n;
      RST        = 1'b1;
      req_valid  = 4'b0000;
      req_data   = 32'h0;
      force_busy = 1'b0;
      model_en   = 1'b0;
`ifdef UART_ARB_LOCK_EN
      req_lock   = 4'b0000;
`endif

      // Reset, then idle with no requests.
      step();
      step();
      chk("reset_outputs", 32'({tx_data_valid, tx_p_data, req_ready, grant_id, arb_busy, tmo_err}), 32'd0);
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_outputs", 32'({tx_data_valid, tx_p_data, req_ready, grant_id, arb_busy, tmo_err}), 32'd0);
      end

      // Single request from 2, one-cycle latency; valid dropped after grant; early Busy.
      req_valid = 4'b0100;
      req_data[23:16] = 8'hA5;
      step();
      chk("single_valid", 32'(tx_data_valid), 32'd1);
      chk("single_data",  32'(tx_p_data),     32'hA5);
      chk("single_ready", 32'(req_ready),     32'b0100);
      chk("single_gnt",   32'(grant_id),      32'd2);
      chk("single_busy",  32'(arb_busy),      32'd1);
      req_valid  = 4'b0000;
      force_busy = 1'b1;
      step();
      chk("post_issue_valid", 32'({tx_data_valid, req_ready}), 32'd0);
      chk("data_held",        32'(tx_p_data),  32'hA5);
      step();
      step();
      chk("wait_fall_busy", 32'({arb_busy, tmo_err}), 32'b10);
      force_busy = 1'b0;
      step();
      chk("back_to_idle", 32'(arb_busy), 32'd0);
      chk("data_held_idle", 32'(tx_p_data), 32'hA5);

      // All four valid with TX model: strict rotation 0,1,2,3,0.
      do_reset();
      model_en  = 1'b1;
      req_data  = 32'h13121110;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_issue(40);
         chk("rot_gnt",   32'(grant_id),  32'(k % 4));
         chk("rot_data",  32'(tx_p_data), 32'(8'h10 + 8'(k % 4)));
         chk("rot_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      end
      req_valid = 4'b0000;
      wait_idle(40);

      // Single requester continuously valid: 14-cycle frame period, one idle cycle gap.
      req_valid = 4'b0001;
      req_data[7:0] = 8'h3C;
      wait_issue(40);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            step();
            n++;
         end while (!tx_data_valid && n < 40);
         chk("b2b_period", 32'(n), 32'd14);
      end
      req_valid = 4'b0000;
      wait_idle(40);
      model_en = 1'b0;

      // Watchdog: TX never raises Busy.
      req_valid = 4'b0001;
      step();
      chk("tmo_issue", 32'({tx_data_valid, grant_id}), 32'b100);
      req_valid = 4'b0000;
      early = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (tmo_err) early++;
      end
      chk("tmo_not_early", 32'(early), 32'd0);
      chk("tmo_still_busy", 32'(arb_busy), 32'd1);
      step();
      chk("tmo_pulse", 32'({tmo_err, arb_busy}), 32'b10);
      req_valid = 4'b0001;
      step();
      chk("tmo_regrant", 32'({tx_data_valid, tmo_err}), 32'b10);
      req_valid  = 4'b0000;
      force_busy = 1'b1;
      step();
      step();
      force_busy = 1'b0;
      wait_idle(10);

      // Reset during WAIT_FALL with Busy high: no grant until Busy falls.
      req_valid = 4'b0010;
      req_data[15:8] = 8'h5A;
      step();
      chk("rst_issue", 32'(tx_data_valid), 32'd1);
      force_busy = 1'b1;
      step();
      step();
      chk("rst_wait_fall", 32'(arb_busy), 32'd1);
      RST = 1'b1;
      step();
      chk("rst_outputs", 32'({tx_data_valid, tx_p_data, req_ready, grant_id, arb_busy, tmo_err}), 32'd0);
      RST = 1'b0;
      early = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (tx_data_valid || arb_busy) early++;
      end
      chk("rst_no_grant", 32'(early), 32'd0);
      force_busy = 1'b0;
      step();
      chk("rst_regrant",      32'({tx_data_valid, grant_id}), 32'b101);
      chk("rst_regrant_data", 32'(tx_p_data), 32'h5A);
      chk("rst_regrant_rdy",  32'(req_ready), 32'b0010);
      req_valid  = 4'b0000;
      force_busy = 1'b1;
      step();
      step();
      force_busy = 1'b0;
      wait_idle(10);

`ifdef UART_ARB_LOCK_EN
      // Lock on requester 1: three bytes from 1, then 2 after the lock drops.
      do_reset();
      model_en  = 1'b1;
      req_data  = 32'h00221100;
      req_lock  = 4'b0010;
      req_valid = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         wait_issue(40);
         chk("lock_gnt",  32'(grant_id),  32'd1);
         chk("lock_data", 32'(tx_p_data), 32'h11);
      end
      req_lock = 4'b0000;
      wait_issue(40);
      chk("unlock_gnt",  32'(grant_id),  32'd2);
      chk("unlock_data", 32'(tx_p_data), 32'h22);
      req_valid = 4'b0000;
      wait_idle(40);
      model_en = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
